// File: rtl/spi_slave_param_if.sv
// Client-side TX/RX valid/ready bundle between spi_slave_param and its
// register-bank or DMA consumer.
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: all four CPOL/CPHA modes, one-entry TX holding
// buffer, RX valid/ready output and sticky overrun/underrun/frame flags.
module spi_slave_param #(
  parameter int                DATA_W      = 8,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_DEFAULT  = {DATA_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  spi_slave_param_if.slave bus,
  output logic             busy,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err,
  input  logic             status_clr
);
  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, ss_sync_reg;
  logic                   sclk_s, mosi_s, ss_s, sclk_prev_reg;
  logic                   cpol_reg, cpha_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [DATA_W-1:0]      rx_shift_reg, rx_data_reg, tx_shift_reg, tx_buf_reg;
  logic                   rx_valid_reg, word_done_reg, tx_full_reg, miso_reg;
  logic                   rx_overrun_reg, tx_underrun_reg, frame_err_reg;
  logic                   frame_start, frame_end, selected, sclk_edge;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   tx_load, tx_write, overrun_set, underrun_set, ferr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      ss_sync_reg   <= '1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_reg)
      ST_IDLE: if (!ss_s) begin
        state_next  = ST_ACTIVE;
        frame_start = 1'b1;
      end
      ST_ACTIVE: if (ss_s) begin
        state_next = ST_IDLE;
        frame_end  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Edges are classified against the cpol/cpha captured at frame start.
  assign selected    = (state_reg == ST_ACTIVE) && !ss_s;
  assign sclk_edge   = selected && (sclk_s != sclk_prev_reg);
  assign lead_edge   = sclk_edge && (sclk_s != cpol_reg);
  assign trail_edge  = sclk_edge && (sclk_s == cpol_reg);
  assign sample_edge = cpha_reg ? trail_edge : lead_edge;
  assign shift_edge  = cpha_reg ? lead_edge : trail_edge;

  assign tx_load      = (frame_start && !cpha) || (shift_edge && (bit_cnt_reg == '0));
  assign tx_write     = bus.tx_valid && !tx_full_reg;
  assign overrun_set  = word_done_reg && rx_valid_reg && !bus.rx_ready;
  assign underrun_set = tx_load && !tx_full_reg;
  assign ferr_set     = frame_end && (bit_cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_reg   <= 1'b0;
      cpol_reg        <= 1'b0;
      cpha_reg        <= 1'b0;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      word_done_reg   <= 1'b0;
      tx_shift_reg    <= '0;
      tx_buf_reg      <= '0;
      tx_full_reg     <= 1'b0;
      miso_reg        <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      word_done_reg <= 1'b0;

      if (frame_start) begin
        cpol_reg    <= cpol;
        cpha_reg    <= cpha;
        bit_cnt_reg <= '0;
      end else if (frame_end) begin
        bit_cnt_reg <= '0;
      end else if (sample_edge) begin
        rx_shift_reg <= MSB_FIRST ? {rx_shift_reg[DATA_W-2:0], mosi_s}
                                  : {mosi_s, rx_shift_reg[DATA_W-1:1]};
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_reg   <= '0;
          word_done_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      // rx_shift already holds the full word one cycle after the last sample.
      if (word_done_reg) begin
        rx_data_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_valid_reg && bus.rx_ready) begin
        rx_valid_reg <= 1'b0;
      end

      if (tx_load) begin
        tx_shift_reg <= tx_full_reg ? tx_buf_reg : TX_DEFAULT;
      end else if (shift_edge) begin
        tx_shift_reg <= MSB_FIRST ? {tx_shift_reg[DATA_W-2:0], 1'b0}
                                  : {1'b0, tx_shift_reg[DATA_W-1:1]};
      end

      // A write into an empty buffer coinciding with a load stays buffered.
      if (tx_load && tx_full_reg) begin
        tx_full_reg <= 1'b0;
      end else if (tx_write) begin
        tx_full_reg <= 1'b1;
        tx_buf_reg  <= bus.tx_data;
      end

      if (state_next == ST_ACTIVE)
        miso_reg <= MSB_FIRST ? tx_shift_reg[DATA_W-1] : tx_shift_reg[0];
      else
        miso_reg <= 1'b0;

      rx_overrun_reg  <= overrun_set  | (rx_overrun_reg  & ~status_clr);
      tx_underrun_reg <= underrun_set | (tx_underrun_reg & ~status_clr);
      frame_err_reg   <= ferr_set     | (frame_err_reg   & ~status_clr);
    end
  end

  assign miso         = miso_reg;
  assign miso_oe      = (state_reg == ST_ACTIVE);
  assign busy         = (state_reg == ST_ACTIVE);
  assign bus.tx_ready = !tx_full_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign rx_overrun   = rx_overrun_reg;
  assign tx_underrun  = tx_underrun_reg;
  assign frame_err    = frame_err_reg;
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave, successor to the fixed 8-bit slave. It adds configurable word width, bit order and synchroniser depth, plus all four CPOL/CPHA modes latched per frame. Continuous multi-word frames use a one-entry TX holding buffer with valid/ready handshakes on both the TX and RX sides. Sticky error flags report overrun, underrun and aborted frames. Sits between the SPI pads and a register-bank/DMA client inside the peripheral subsystem.

Parameters:
DATA_W, 8, word width in bits (≥2)
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO; 0 = LSB first
SYNC_STAGES, 2, flop stages on sclk/mosi/ss_n (≥2)
TX_DEFAULT, {DATA_W{1'b1}}, word shifted out when the TX buffer is empty at word load

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sclk  in  1  SPI clock from master (asynchronous)
ss_n  in  1  active-low slave select (asynchronous)
mosi  in  1  master-out slave-in (asynchronous)
miso  out  1  slave-out; 0 when not selected
miso_oe  out  1  pad output enable; high while selected
cpol  in  1  idle level of sclk, latched at frame start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX buffer empty (accepts a word)
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid; held until accepted
rx_ready  in  1  consumer accepts rx_data
busy  out  1  frame in progress (synchronised ss_n low)
rx_overrun  out  1  sticky: word completed while rx_valid was high
tx_underrun  out  1  sticky: word loaded from TX_DEFAULT
frame_err  out  1  sticky: ss_n rose mid-word
status_clr  in  1  clears all three sticky flags

Behaviour:
- Synchronisation: sclk, mosi and ss_n each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk against its registered previous value.
- Timing requirement: each sclk high and low phase must last ≥ SYNC_STAGES+2 clk.
- Frame start: synchronised ss_n falls. On that cycle: latch cpol/cpha, clear bit_cnt, set busy and miso_oe.
- Edge definition: leading edge = sclk leaves the latched cpol level; trailing edge = sclk returns to it.
- Sample edge: leading if cpha=0, trailing if cpha=1. Shift edge: the other one.
- Edges are ignored while not selected.
- Sample edge: shift the synchronised mosi into rx_shift (direction per MSB_FIRST) and increment bit_cnt.
- Word complete: when bit_cnt reaches DATA_W it wraps to 0. On the next clk, rx_data is loaded with the assembled word and rx_valid is set.
  - rx_valid clears on rx_valid&&rx_ready.
  - If rx_valid is still high at word complete: rx_data is overwritten, rx_valid stays high, rx_overrun is set.
- TX word load:
  - cpha=0: the word loads at frame start, and at every shift edge that occurs with bit_cnt==0.
  - cpha=1: the word loads at every shift edge with bit_cnt==0.
  - Source: the TX buffer if full (buffer then empties), otherwise TX_DEFAULT with tx_underrun set.
- All other shift edges advance tx_shift by one bit.
- miso is driven from a register: the current first-out bit of tx_shift while selected, else 0.
- TX buffer:
  - tx_ready = !tx_full.
  - Write when tx_valid&&tx_ready.
  - A word load in the same cycle as a write into an empty buffer uses TX_DEFAULT; the written word stays for the next load.
- Frame end: synchronised ss_n rises.
  - If bit_cnt≠0: discard the partial word, set frame_err, no rx_valid.
  - In all cases: clear bit_cnt, busy and miso_oe; miso=0.
  - A loaded tx word is not restored to the buffer.
- Sticky flags: status_clr clears them. If set and clear occur in the same cycle, set wins.
- cpol/cpha changes mid-frame have no effect.
- Reset:
  - Outputs: miso, miso_oe, busy, rx_valid, rx_data and all flags = 0; tx_ready=1.
  - Synchroniser flops: ss_n flops=1, sclk/mosi flops=0.
  - Internal state: TX buffer empty, bit_cnt=0.
  - Reset mid-frame abandons the frame without setting frame_err.

Test Plan:
- Mode 0, DATA_W=8, MSB_FIRST=1: preload tx 0xA5, master sends 0x3C → rx_data=0x3C with rx_valid held until rx_ready; master receives 0xA5; no flags.
- Modes 1/2/3 each: same exchange with tx 0x5A and master 0xC3 → rx_data=0xC3, master receives 0x5A; cpol toggled mid-frame → no effect.
- Two-word frame, tx buffer refilled after first load: tx 0x11 then 0x22, master sends 0x81,0x42 → two rx_valid events 0x81,0x42; MISO 0x11,0x22 with no gap.
- Empty buffer at load → master receives 0xFF, tx_underrun=1; hold rx_ready=0 across two words → rx_overrun=1, rx_data=second word; status_clr → flags 0.
- ss_n rises after 5 bits → frame_err=1, no rx_valid, next frame received correctly (0x96).
- DATA_W=12, MSB_FIRST=0: tx 0x9A3, master sends 0x5C1 LSB first → rx_data=0x5C1, master receives 0x9A3; rst asserted mid-word → all outputs at reset values, tx_ready=1.
